swap_rotate_fsm: RTL and testbench
==================================

Name: swap_rotate_fsm

Overview:
Parametrised successor to the team's 3-step swap controller. It embeds a NUM_REGS x DATA_W register bank plus one temp register, and runs multi-cycle commands on that bank. Commands are a pairwise swap of any two entries through the temp register, or a full rotate-left of the bank. It sits between a host command interface and the register bank, and exposes busy/done handshake signals and a step indicator for datapath muxing.

Parameters:
DATA_W, 8, width of each bank entry and of temp register
NUM_REGS, 4, number of bank entries (2..16); index width IDX_W = $clog2(NUM_REGS) as localparam

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
start  in  1  command request; accepted only in IDLE
mode  in  1  0 = swap idx_a/idx_b, 1 = rotate-left whole bank (see Optional Feature)
idx_a  in  IDX_W  swap operand A
idx_b  in  IDX_W  swap operand B
wr_en  in  1  host load strobe
wr_idx  in  IDX_W  host load index
wr_data  in  DATA_W  host load data
rd_idx  in  IDX_W  host read index
rd_data  out  DATA_W  combinational read of bank[rd_idx]
busy  out  1  high from the cycle after acceptance until the command completes
done  out  1  registered one-cycle pulse, asserted the cycle after the last write
err  out  1  registered one-cycle pulse on a rejected command
step  out  2  0 idle, 1 load-temp, 2 move, 3 store-temp
w  out  1  bank write strobe; equals busy

Behaviour:
- Reset state (next clk edge with reset=1, including mid-command):
  - state IDLE; all bank entries, temp and loop counter cleared to 0.
  - busy=0, done=0, err=0, step=0, w=0; any in-flight command is abandoned.
- Acceptance: start=1 in IDLE with legal indices.
  - idx_a, idx_b and mode are captured into internal registers.
  - Input changes after acceptance have no effect on the running command.
- Illegal index: a swap with idx_a or idx_b >= NUM_REGS (non-power-of-2 NUM_REGS only).
  - Command is rejected: err pulses the next cycle, state stays IDLE, bank is unchanged.
- Swap sequence: IDLE -> LOAD (temp<=bank[a]) -> MOVE (bank[a]<=bank[b]) -> STORE (bank[b]<=temp) -> IDLE.
  - busy is high for exactly 3 cycles; done pulses on the first IDLE cycle.
- idx_a == idx_b: the full 3-step sequence still runs; bank contents are unchanged; done pulses normally.
- Rotate sequence: IDLE -> LOAD (temp<=bank[0]) -> SHIFT -> STORE (bank[N-1]<=temp) -> IDLE.
  - SHIFT lasts NUM_REGS-1 cycles, one entry per cycle: bank[i]<=bank[i+1] for i=0..N-2, with the counter incrementing each cycle.
  - step=2 throughout SHIFT.
  - Total busy = NUM_REGS+1 cycles.
- start while busy: ignored; no queueing and no err.
- wr_en:
  - Honoured only in IDLE with no start accepted that same cycle. If start and wr_en arrive together, start wins and the write is dropped.
  - wr_en while busy is dropped.
  - wr_idx >= NUM_REGS is dropped silently.
- rd_data is valid every cycle, including mid-command; it shows intermediate bank contents.
- done and err are never high in the same cycle; neither is asserted while busy=1.

Optional Feature:
Macro SWAP_ROTATE_EN.
- Defined: the mode input selects rotate-left as described above.
- Undefined: mode is ignored, every command executes as a swap, and the SHIFT state and loop counter are not synthesised.

Test Plan:
1. Reset, load bank = {0x11,0x22,0x33,0x44}; start mode=0 a=0 b=3 -> busy high 3 cycles, step 1,2,3; then done pulse; bank = {0x44,0x22,0x33,0x11}.
2. Same bank, start a=2 b=2 -> 3 busy cycles, done pulse, bank unchanged; then start issued during busy -> ignored, exactly one done.
3. SWAP_ROTATE_EN defined, bank {0x11,0x22,0x33,0x44}, start mode=1 -> busy 5 cycles, bank = {0x22,0x33,0x44,0x11}, done pulse. Without the macro, the same stimulus performs a swap of idx_a/idx_b.
4. Assert reset during MOVE of a swap -> next cycle busy=0, step=0, bank all 0x00, no done pulse.
5. NUM_REGS=3, start a=3 b=0 -> err pulse 1 cycle, busy stays 0, bank unchanged.
6. In IDLE, wr_en and start asserted in the same cycle (wr_idx=1, data 0xAA) -> command runs and bank[1] is not written; wr_en asserted while busy -> dropped.

Source files
------------

// File: rtl/swap_rotate_fsm.sv
// Multi-cycle swap / rotate-left controller around an embedded NUM_REGS x DATA_W register bank.
// Optional rotate-left command is compiled in with `define SWAP_ROTATE_EN; default build is swap-only.
module swap_rotate_fsm #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4,
  localparam int IDX_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [IDX_W-1:0]  idx_a,
  input  logic [IDX_W-1:0]  idx_b,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        step,
  output logic              w
);

  localparam logic [IDX_W:0] NUM_L = (IDX_W+1)'(NUM_REGS);

`ifdef SWAP_ROTATE_EN
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
  localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(NUM_REGS - 2);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MOVE, S_SHIFT, S_STORE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MOVE, S_STORE} state_t;
`endif

  state_t state_q, state_d;

  logic [DATA_W-1:0] bank [NUM_REGS];
  logic [DATA_W-1:0] temp;
  logic [IDX_W-1:0]  a_q, b_q;
  logic              accept, reject, start_rot;

`ifdef SWAP_ROTATE_EN
  logic              rot_q;
  logic [IDX_W-1:0]  cnt_q;
  assign start_rot = mode;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign start_rot   = 1'b0;
`endif

  // Index checks are constant-true for power-of-2 bank sizes.
  logic a_ok, b_ok, wr_ok, rd_ok;
  assign a_ok  = {1'b0, idx_a}  < NUM_L;
  assign b_ok  = {1'b0, idx_b}  < NUM_L;
  assign wr_ok = {1'b0, wr_idx} < NUM_L;
  assign rd_ok = {1'b0, rd_idx} < NUM_L;

  assign rd_data = rd_ok ? bank[rd_idx] : '0;
  assign busy    = (state_q != S_IDLE);
  assign w       = busy;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    reject  = 1'b0;
    step    = 2'd0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (!start_rot && !(a_ok && b_ok)) begin
            reject = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        step    = 2'd1;
`ifdef SWAP_ROTATE_EN
        state_d = rot_q ? S_SHIFT : S_MOVE;
`else
        state_d = S_MOVE;
`endif
      end
      S_MOVE: begin
        step    = 2'd2;
        state_d = S_STORE;
      end
`ifdef SWAP_ROTATE_EN
      S_SHIFT: begin
        step = 2'd2;
        if (cnt_q == CNT_LAST) state_d = S_STORE;
      end
`endif
      S_STORE: begin
        step    = 2'd3;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      temp    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
`ifdef SWAP_ROTATE_EN
      rot_q   <= 1'b0;
      cnt_q   <= '0;
`endif
      for (int i = 0; i < NUM_REGS; i++) bank[i] <= '0;
    end else begin
      state_q <= state_d;
      done    <= (state_q == S_STORE);
      err     <= reject;
      if (accept) begin
        a_q <= idx_a;
        b_q <= idx_b;
`ifdef SWAP_ROTATE_EN
        rot_q <= mode;
        cnt_q <= '0;
`endif
      end
      case (state_q)
        // A start accepted this cycle takes priority over a host load.
        S_IDLE: if (!accept && wr_en && wr_ok) bank[wr_idx] <= wr_data;
`ifdef SWAP_ROTATE_EN
        S_LOAD:  temp <= rot_q ? bank[0] : bank[a_q];
        S_MOVE:  bank[a_q] <= bank[b_q];
        S_SHIFT: begin
          bank[cnt_q] <= bank[cnt_q + 1'b1];
          cnt_q       <= cnt_q + 1'b1;
        end
        S_STORE: bank[rot_q ? LAST_IDX : b_q] <= temp;
`else
        S_LOAD:  temp <= bank[a_q];
        S_MOVE:  bank[a_q] <= bank[b_q];
        S_STORE: bank[b_q] <= temp;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_swap_rotate_fsm.sv
// Directed bench for swap_rotate_fsm: a NUM_REGS=4 instance for the main flows and a NUM_REGS=3
// instance for illegal-index rejection; rotate expectations follow SWAP_ROTATE_EN.
module tb_swap_rotate_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, mode, wr_en;
  logic [1:0] idx_a, idx_b, wr_idx, rd_idx, step;
  logic [7:0] wr_data, rd_data;
  logic       busy, done, err, w;

  logic       start3, mode3, wr_en3;
  logic [1:0] idx_a3, idx_b3, wr_idx3, rd_idx3, step3;
  logic [7:0] wr_data3, rd_data3;
  logic       busy3, done3, err3, w3;

  int n_checks = 0;
  int n_fail   = 0;

  swap_rotate_fsm #(.DATA_W(8), .NUM_REGS(4)) u_dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .idx_a(idx_a), .idx_b(idx_b),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .rd_idx(rd_idx), .rd_data(rd_data),
    .busy(busy), .done(done), .err(err), .step(step), .w(w)
  );

  swap_rotate_fsm #(.DATA_W(8), .NUM_REGS(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3), .mode(mode3), .idx_a(idx_a3), .idx_b(idx_b3),
    .wr_en(wr_en3), .wr_idx(wr_idx3), .wr_data(wr_data3), .rd_idx(rd_idx3), .rd_data(rd_data3),
    .busy(busy3), .done(done3), .err(err3), .step(step3), .w(w3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] i, input logic [7:0] d);
    wr_en = 1'b1; wr_idx = i; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wr3(input logic [1:0] i, input logic [7:0] d);
    wr_en3 = 1'b1; wr_idx3 = i; wr_data3 = d;
    tick();
    wr_en3 = 1'b0;
  endtask

  task automatic chk_bank(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                          input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] e [4];
    e = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++) begin
      rd_idx = 2'(i);
      #1;
      check_eq($sformatf("%s bank[%0d]", tag, i), rd_data, e[i]);
    end
    rd_idx = 2'd0;
  endtask

  task automatic chk_bank3(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2);
    logic [7:0] e [3];
    e = '{e0, e1, e2};
    for (int i = 0; i < 3; i++) begin
      rd_idx3 = 2'(i);
      #1;
      check_eq($sformatf("%s bank3[%0d]", tag, i), rd_data3, e[i]);
    end
    rd_idx3 = 2'd0;
  endtask

  // Issues one command, walks the busy window checking step/w/done, optionally pokes start and
  // wr_en while busy, checks one bank entry on the last busy cycle, then the done pulse.
  task automatic run_cmd(input string tag, input logic m, input logic [1:0] a, input logic [1:0] b,
                         input int exp_busy, input bit wr_same, input bit poke,
                         input logic [1:0] mid_idx, input logic [7:0] mid_exp);
    int nbusy;
    logic [1:0] exp_step;
    start = 1'b1; mode = m; idx_a = a; idx_b = b;
    wr_en = wr_same; wr_idx = 2'd1; wr_data = 8'hAA;
    tick();
    start = 1'b0; wr_en = 1'b0; idx_a = ~a; idx_b = ~b; mode = ~m;
    nbusy = 0;
    while (busy === 1'b1 && nbusy < 40) begin
      exp_step = (nbusy == 0) ? 2'd1 : (nbusy == exp_busy - 1) ? 2'd3 : 2'd2;
      check_eq($sformatf("%s step@%0d", tag, nbusy), step, exp_step);
      check_eq($sformatf("%s w@%0d", tag, nbusy), w, 1);
      check_eq($sformatf("%s done_busy@%0d", tag, nbusy), done, 0);
      if (nbusy == exp_busy - 1) begin
        rd_idx = mid_idx;
        #1;
        check_eq({tag, " mid rd"}, rd_data, mid_exp);
        rd_idx = 2'd0;
      end
      if (poke) begin
        start = 1'b1; wr_en = 1'b1; wr_idx = 2'd1; wr_data = 8'hEE;
      end
      tick();
      nbusy++;
    end
    start = 1'b0; wr_en = 1'b0;
    check_eq({tag, " busy cycles"}, nbusy, exp_busy);
    check_eq({tag, " done pulse"}, done, 1);
    check_eq({tag, " err"}, err, 0);
    check_eq({tag, " step idle"}, step, 0);
    tick();
    check_eq({tag, " done cleared"}, done, 0);
    check_eq({tag, " no restart"}, busy, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 1'b0; idx_a = '0; idx_b = '0;
    wr_en = 1'b0; wr_idx = '0; wr_data = '0; rd_idx = '0;
    start3 = 1'b0; mode3 = 1'b0; idx_a3 = '0; idx_b3 = '0;
    wr_en3 = 1'b0; wr_idx3 = '0; wr_data3 = '0; rd_idx3 = '0;
    tick();
    tick();
    reset = 1'b0;

    check_eq("rst busy", busy, 0);
    check_eq("rst done", done, 0);
    check_eq("rst err", err, 0);
    check_eq("rst step", step, 0);
    check_eq("rst w", w, 0);
    chk_bank("rst", 8'h00, 8'h00, 8'h00, 8'h00);

    // Swap ends
    wr(2'd0, 8'h11); wr(2'd1, 8'h22); wr(2'd2, 8'h33); wr(2'd3, 8'h44);
    chk_bank("load", 8'h11, 8'h22, 8'h33, 8'h44);
    run_cmd("swap03", 1'b0, 2'd0, 2'd3, 3, 1'b0, 1'b0, 2'd0, 8'h44);
    chk_bank("swap03", 8'h44, 8'h22, 8'h33, 8'h11);

    // Self-swap with start/wr_en poked while busy
    run_cmd("swap22", 1'b0, 2'd2, 2'd2, 3, 1'b0, 1'b1, 2'd2, 8'h33);
    chk_bank("swap22", 8'h44, 8'h22, 8'h33, 8'h11);

    // Rotate request (swap of 1/2 when rotate is not built)
    wr(2'd0, 8'h11); wr(2'd1, 8'h22); wr(2'd2, 8'h33); wr(2'd3, 8'h44);
`ifdef SWAP_ROTATE_EN
    run_cmd("rot", 1'b1, 2'd1, 2'd2, 5, 1'b0, 1'b0, 2'd1, 8'h33);
    chk_bank("rot", 8'h22, 8'h33, 8'h44, 8'h11);
`else
    run_cmd("rot", 1'b1, 2'd1, 2'd2, 3, 1'b0, 1'b0, 2'd1, 8'h33);
    chk_bank("rot", 8'h11, 8'h33, 8'h22, 8'h44);
`endif

    // start and wr_en together: start wins; writes during busy dropped
    run_cmd("swap01", 1'b0, 2'd0, 2'd1, 3, 1'b1, 1'b1, 2'd0, 8'h33);
`ifdef SWAP_ROTATE_EN
    chk_bank("swap01", 8'h33, 8'h22, 8'h44, 8'h11);
`else
    chk_bank("swap01", 8'h33, 8'h11, 8'h22, 8'h44);
`endif

    // Reset during MOVE
    start = 1'b1; mode = 1'b0; idx_a = 2'd0; idx_b = 2'd3;
    tick();
    start = 1'b0;
    check_eq("rstmid load step", step, 1);
    tick();
    check_eq("rstmid move step", step, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("rstmid busy", busy, 0);
    check_eq("rstmid step", step, 0);
    check_eq("rstmid done", done, 0);
    chk_bank("rstmid", 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    check_eq("rstmid no done", done, 0);
    check_eq("rstmid still idle", busy, 0);

    // NUM_REGS=3: out-of-range write dropped, illegal swap rejected
    wr3(2'd0, 8'h5A); wr3(2'd1, 8'h6B); wr3(2'd2, 8'h7C); wr3(2'd3, 8'hFF);
    chk_bank3("load3", 8'h5A, 8'h6B, 8'h7C);
    start3 = 1'b1; idx_a3 = 2'd3; idx_b3 = 2'd0;
    tick();
    start3 = 1'b0;
    check_eq("ill err", err3, 1);
    check_eq("ill busy", busy3, 0);
    check_eq("ill done", done3, 0);
    tick();
    check_eq("ill err cleared", err3, 0);
    check_eq("ill still idle", busy3, 0);
    chk_bank3("ill", 8'h5A, 8'h6B, 8'h7C);

    // Legal swap on the 3-entry bank
    start3 = 1'b1; idx_a3 = 2'd2; idx_b3 = 2'd0;
    tick();
    start3 = 1'b0;
    check_eq("sw3 busy", busy3, 1);
    tick(); tick(); tick();
    check_eq("sw3 done", done3, 1);
    check_eq("sw3 err", err3, 0);
    chk_bank3("sw3", 8'h7C, 8'h6B, 8'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
